// File: rtl/spu_sb_pkg.sv
// Shared sizing and types for the register scoreboard.
// Top-level build option SB_FWD_EN is consumed by reg_scoreboard, not here.
package spu_sb_pkg;

    localparam int NUM_REGS = 128;
    localparam int LAT_W    = 3;
    localparam int ADDR_W   = 7;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [LAT_W-1:0]  lat_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: a per-register down-counter of cycles until the
// pending write lands, plus a registered busy flag that mirrors (cnt != 0).
module sb_entry #(
    parameter int LAT_W = spu_sb_pkg::LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic [LAT_W-1:0] load_lat,
    output logic [LAT_W-1:0] cnt,
    output logic             busy
);

    logic [LAT_W-1:0] cnt_nxt;

    // A reload wins over the decrement of an older pending write.
    always_comb begin
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_lat;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-pipe (even/odd) register scoreboard with RAW, WAW and pair hazard checks.
// Define SB_FWD_EN to let a source whose write lands next cycle issue (forwarding).
module reg_scoreboard #(
    parameter int NUM_REGS = spu_sb_pkg::NUM_REGS,
    parameter int LAT_W    = spu_sb_pkg::LAT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid_ep,
    input  logic                  issue_valid_op,
    input  spu_sb_pkg::reg_addr_t issue_rt_ep,
    input  spu_sb_pkg::reg_addr_t issue_rt_op,
    input  logic                  issue_wr_ep,
    input  logic                  issue_wr_op,
    input  logic [LAT_W-1:0]      issue_lat_ep,
    input  logic [LAT_W-1:0]      issue_lat_op,
    input  spu_sb_pkg::reg_addr_t src_ra_ep,
    input  spu_sb_pkg::reg_addr_t src_rb_ep,
    input  spu_sb_pkg::reg_addr_t src_rc_ep,
    input  spu_sb_pkg::reg_addr_t src_ra_op,
    input  spu_sb_pkg::reg_addr_t src_rb_op,
    input  spu_sb_pkg::reg_addr_t src_rc_op,
    input  logic [2:0]            src_use_ep,
    input  logic [2:0]            src_use_op,
    input  logic                  flush,
    output logic                  issue_ack_ep,
    output logic                  issue_ack_op,
    output logic [NUM_REGS-1:0]   busy_vec
);

    import spu_sb_pkg::*;

    // Handshake: issue_valid_x is a request held by the issuer; issue_ack_x is
    // combinational and means the instruction is accepted (and any write
    // recorded) at this rising edge. Without ack the issuer retries next cycle.

    logic [LAT_W-1:0] cnt [NUM_REGS];

    function automatic logic src_blocked(input logic [LAT_W-1:0] c);
`ifdef SB_FWD_EN
        return c > LAT_W'(1);
`else
        return c != '0;
`endif
    endfunction

    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
        return (l == '0) ? LAT_W'(1) : l;
    endfunction

    logic [LAT_W-1:0] cnt_ra_ep, cnt_rb_ep, cnt_rc_ep, cnt_rt_ep;
    logic [LAT_W-1:0] cnt_ra_op, cnt_rb_op, cnt_rc_op, cnt_rt_op;
    logic [LAT_W-1:0] lat_eff_ep, lat_eff_op;
    logic             raw_ep, raw_op, waw_ep, waw_op, pair_op;

    assign cnt_ra_ep = cnt[src_ra_ep];
    assign cnt_rb_ep = cnt[src_rb_ep];
    assign cnt_rc_ep = cnt[src_rc_ep];
    assign cnt_rt_ep = cnt[issue_rt_ep];
    assign cnt_ra_op = cnt[src_ra_op];
    assign cnt_rb_op = cnt[src_rb_op];
    assign cnt_rc_op = cnt[src_rc_op];
    assign cnt_rt_op = cnt[issue_rt_op];

    assign lat_eff_ep = eff_lat(issue_lat_ep);
    assign lat_eff_op = eff_lat(issue_lat_op);

    assign raw_ep = (src_use_ep[0] & src_blocked(cnt_ra_ep))
                  | (src_use_ep[1] & src_blocked(cnt_rb_ep))
                  | (src_use_ep[2] & src_blocked(cnt_rc_ep));
    assign raw_op = (src_use_op[0] & src_blocked(cnt_ra_op))
                  | (src_use_op[1] & src_blocked(cnt_rb_op))
                  | (src_use_op[2] & src_blocked(cnt_rc_op));

    // An older write landing with or after the new one would clobber it.
    assign waw_ep = issue_wr_ep & (cnt_rt_ep >= lat_eff_ep);
    assign waw_op = issue_wr_op & (cnt_rt_op >= lat_eff_op);

    // The even pipe is older in program order, so only the odd side yields.
    assign pair_op = issue_valid_ep & issue_valid_op & issue_wr_ep
                   & ( (src_use_op[0] & (issue_rt_ep == src_ra_op))
                     | (src_use_op[1] & (issue_rt_ep == src_rb_op))
                     | (src_use_op[2] & (issue_rt_ep == src_rc_op))
                     | (issue_wr_op   & (issue_rt_ep == issue_rt_op)) );

    assign issue_ack_ep = reset & ~flush & issue_valid_ep & ~raw_ep & ~waw_ep;
    assign issue_ack_op = reset & ~flush & issue_valid_op & ~raw_op & ~waw_op
                        & ~pair_op;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        logic             load_ep, load_op;
        logic [LAT_W-1:0] load_lat;

        assign load_ep  = issue_ack_ep & issue_wr_ep & (issue_rt_ep == reg_addr_t'(g));
        assign load_op  = issue_ack_op & issue_wr_op & (issue_rt_op == reg_addr_t'(g));
        assign load_lat = load_ep ? lat_eff_ep : lat_eff_op;

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .load     (load_ep | load_op),
            .load_lat (load_lat),
            .cnt      (cnt[g]),
            .busy     (busy_vec[g])
        );
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 128, number of architectural registers tracked.
REQ-002 Parameter LAT_W, default 3, width of the per-register latency counter (max latency 7).
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port issue_valid_ep, issue_valid_op  input  1 each  even/odd pipe requests issue this cycle.
REQ-006 Port issue_rt_ep, issue_rt_op  input  7 each  destination register of the issuing instruction.
REQ-007 Port issue_wr_ep, issue_wr_op  input  1 each  instruction writes rt.
REQ-008 Port issue_lat_ep, issue_lat_op  input  LAT_W each  cycles from issue to register-file write, legal 1..7.
REQ-009 Port src_ra/rb/rc_ep, src_ra/rb/rc_op  input  7 each  source register addresses.
REQ-010 Port src_use_ep, src_use_op  input  3 each  bit0=ra, bit1=rb, bit2=rc are read.
REQ-011 Port flush  input  1  synchronous clear of all pending entries.
REQ-012 Port issue_ack_ep, issue_ack_op  output  1 each  combinational; instruction accepted this cycle.
REQ-013 Port busy_vec  output  NUM_REGS  registered; bit n set while register n has a pending write.

Function
REQ-014 Each register SHALL own a LAT_W-bit down-counter cnt[n]; busy_vec[n] = (cnt[n] != 0).
REQ-015 Every cycle, each nonzero cnt[n] SHALL decrement by 1 unless reloaded that cycle.
REQ-016 On accepted issue with wr=1, cnt[rt] SHALL load issue_lat on the next edge (reload overrides decrement).
REQ-017 issue_ack_x = issue_valid_x AND no RAW hazard AND no WAW hazard AND no pair hazard, and never while flush=1.
REQ-018 RAW hazard: any used source address with cnt != 0 (forwarding variant in REQ-031).
REQ-019 WAW hazard: issue_wr=1 and cnt[rt] >= issue_lat (older write would land after or with the new one).
REQ-020 Pair hazard, odd side: both pipes valid, issue_wr_ep=1, and issue_rt_ep matches any used odd source or issue_rt_op (with issue_wr_op=1); odd pipe SHALL NOT be acked.
REQ-021 Even pipe acceptance SHALL NOT depend on the odd pipe; odd stall never blocks even.
REQ-022 issue_lat of 0 SHALL be treated as 1.
REQ-023 flush=1: all counters SHALL clear to 0 on the next edge; both acks 0 that cycle.
REQ-024 Issue with issue_wr=0 SHALL change no counter.
REQ-025 Register 0 receives no special treatment; all NUM_REGS entries are identical.

Reset
REQ-026 reset low SHALL asynchronously clear all cnt to 0 and busy_vec to all-zero.
REQ-027 While reset is low, issue_ack_ep and issue_ack_op SHALL be 0.
REQ-028 First edge after reset release SHALL accept issues with no hazards reported.
REQ-029 Reset mid-operation SHALL discard all pending entries with no residual busy bits.

Configuration
REQ-030 Macro SB_FWD_EN selects result forwarding.
REQ-031 With SB_FWD_EN defined, a source with cnt == 1 SHALL NOT raise RAW hazard; without it, any cnt != 0 is a hazard.

Structure
REQ-032 Package spu_sb_pkg SHALL hold NUM_REGS, LAT_W, register-address typedef (7-bit) and latency typedef.
REQ-033 One sub-module sb_entry SHALL implement a single counter (load, decrement, clear, busy), instantiated NUM_REGS times.

Verification
REQ-034 Even issue rt=5 lat=3, then odd reads r5 each cycle -> odd ack 0 for 3 cycles, ack 1 on the 4th (SB_FWD_EN: ack on 3rd).
REQ-035 Same cycle even rt=10 wr, odd src ra=10 -> ack_ep=1, ack_op=0; odd acked next cycle only if cnt[10] permits.
REQ-036 r7 pending cnt=4, new issue rt=7 lat=2 -> ack 0 until cnt[7] < 2, then cnt[7] reloads to 2.
REQ-037 Both pipes write rt=20 same cycle -> ack_ep=1, ack_op=0.
REQ-038 Registers 3,9,127 busy, flush=1 -> acks 0 that cycle; busy_vec all-zero next cycle.
REQ-039 Reset asserted with 6 registers busy -> busy_vec zero immediately, acks 0 until release.
